// File: rtl/store_data_buffer_if.sv
// Store/load bus between the store stage and the store data buffer.
// The master side issues stores and loads; the slave side is the buffer.
interface store_data_buffer_if #(
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          st_valid;
    logic [31:0]   st_addr;
    logic [31:0]   st_data;
    logic          st_ready;
    logic          ld_valid;
    logic [31:0]   ld_addr;
    logic [31:0]   ld_data;
    logic          ld_done;
    logic          misaligned;
    logic [CW-1:0] count;

    modport master (
        output st_valid, st_addr, st_data, ld_valid, ld_addr,
        input  st_ready, ld_data, ld_done, misaligned, count
    );

    modport slave (
        input  st_valid, st_addr, st_data, ld_valid, ld_addr,
        output st_ready, ld_data, ld_done, misaligned, count
    );
endinterface

// File: rtl/store_data_buffer.sv
// In-order store buffer draining into a single-port word memory; loads own the
// memory port when present and forward from the youngest matching pending store.
module store_data_buffer #(
    parameter int DEPTH     = 4,
    parameter int MEM_WORDS = 256
) (
    input logic           clk,
    input logic           reset,
    store_data_buffer_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int AW = $clog2(MEM_WORDS);

    logic [31:0]   mem [MEM_WORDS];

    logic [AW-1:0] buf_idx_q  [DEPTH];
    logic [AW-1:0] buf_idx_d  [DEPTH];
    logic [31:0]   buf_data_q [DEPTH];
    logic [31:0]   buf_data_d [DEPTH];
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic [31:0]   ld_data_q, ld_data_d;
    logic          ld_done_q, ld_done_d;
    logic          misaligned_q, misaligned_d;

    logic          st_ready;
    logic          st_aligned;
    logic          ld_aligned;
    logic          push;
    logic          pop;
    logic [AW-1:0] st_idx;
    logic [AW-1:0] ld_idx;
    logic          fwd_hit;
    logic [31:0]   fwd_data;
    logic          unused_addr_bits;

    assign st_idx     = bus.st_addr[AW+1:2];
    assign ld_idx     = bus.ld_addr[AW+1:2];
    assign st_aligned = (bus.st_addr[1:0] == 2'b00);
    assign ld_aligned = (bus.ld_addr[1:0] == 2'b00);
    assign st_ready   = (count_q != CW'(DEPTH));
    assign push       = bus.st_valid && st_ready && st_aligned;
    // Any load, aligned or not, holds the memory port and stalls the drain.
    assign pop        = !bus.ld_valid && (count_q != {CW{1'b0}});

    assign unused_addr_bits = ^{bus.st_addr[31:AW+2], bus.ld_addr[31:AW+2]};

    // Forwarding search, oldest to youngest so the youngest match wins.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = 32'h0000_0000;
        for (int k = 0; k < DEPTH; k++) begin
            if ((CW'(k) < count_q) && (buf_idx_q[head_q + PW'(k)] == ld_idx)) begin
                fwd_hit  = 1'b1;
                fwd_data = buf_data_q[head_q + PW'(k)];
            end else begin
                fwd_hit  = fwd_hit;
                fwd_data = fwd_data;
            end
        end
    end

    // Next-state for buffer, pointers, count and the registered load outputs.
    always_comb begin
        buf_idx_d  = buf_idx_q;
        buf_data_d = buf_data_q;

        if (push) begin
            buf_idx_d[tail_q]  = st_idx;
            buf_data_d[tail_q] = bus.st_data;
            tail_d             = tail_q + PW'(1);
        end else begin
            tail_d = tail_q;
        end

        if (pop) begin
            head_d = head_q + PW'(1);
        end else begin
            head_d = head_q;
        end

        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        ld_done_d = bus.ld_valid;
        if (bus.ld_valid) begin
            if (!ld_aligned) begin
                ld_data_d = 32'h0000_0000;
            end else if (fwd_hit) begin
                ld_data_d = fwd_data;
            end else begin
                ld_data_d = mem[ld_idx];
            end
        end else begin
            ld_data_d = ld_data_q;
        end

        misaligned_d = misaligned_q
                     | (bus.ld_valid && !ld_aligned)
                     | (bus.st_valid && st_ready && !st_aligned);
    end

    // State registers; buffered entries are discarded on reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                buf_idx_q[i]  <= {AW{1'b0}};
                buf_data_q[i] <= 32'h0000_0000;
            end
            head_q       <= {PW{1'b0}};
            tail_q       <= {PW{1'b0}};
            count_q      <= {CW{1'b0}};
            ld_data_q    <= 32'h0000_0000;
            ld_done_q    <= 1'b0;
            misaligned_q <= 1'b0;
        end else begin
            buf_idx_q    <= buf_idx_d;
            buf_data_q   <= buf_data_d;
            head_q       <= head_d;
            tail_q       <= tail_d;
            count_q      <= count_d;
            ld_data_q    <= ld_data_d;
            ld_done_q    <= ld_done_d;
            misaligned_q <= misaligned_d;
        end
    end

    // Memory array is deliberately not reset; pop is idle while count is zero.
    always_ff @(posedge clk) begin
        if (pop) begin
            mem[buf_idx_q[head_q]] <= buf_data_q[head_q];
        end
    end

    assign bus.st_ready   = st_ready;
    assign bus.ld_data    = ld_data_q;
    assign bus.ld_done    = ld_done_q;
    assign bus.misaligned = misaligned_q;
    assign bus.count      = count_q;
endmodule

// File: tb/tb_store_data_buffer.sv
// Directed bench for store_data_buffer with a queue-based reference model
// checked every cycle, plus literal expectations from the documented scenarios.
module tb_store_data_buffer;
    localparam int DEPTH     = 4;
    localparam int MEM_WORDS = 256;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   failures = 0;

    store_data_buffer_if #(.DEPTH(DEPTH)) bus ();

    store_data_buffer #(.DEPTH(DEPTH), .MEM_WORDS(MEM_WORDS)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference model state
    int unsigned q_idx [$];
    logic [31:0] q_data [$];
    logic [31:0] mem_m [MEM_WORDS];
    logic [31:0] m_ld_data = 32'h0;
    logic        m_ld_done = 1'b0;
    logic        m_mis = 1'b0;

    function automatic int unsigned widx(input logic [31:0] a);
        return (a >> 2) % MEM_WORDS;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        int n;
        bit full;
        n    = q_idx.size();
        full = (n == DEPTH);
        m_ld_done = bus.ld_valid;
        if (bus.ld_valid) begin
            if (bus.ld_addr[1:0] != 2'b00) begin
                m_ld_data = 32'h0;
                m_mis     = 1'b1;
            end else begin
                m_ld_data = mem_m[widx(bus.ld_addr)];
                for (int i = 0; i < n; i++)
                    if (q_idx[i] == widx(bus.ld_addr)) m_ld_data = q_data[i];
            end
        end
        if (!bus.ld_valid && n > 0) begin
            mem_m[q_idx[0]] = q_data[0];
            void'(q_idx.pop_front());
            void'(q_data.pop_front());
        end
        if (bus.st_valid && !full) begin
            if (bus.st_addr[1:0] == 2'b00) begin
                q_idx.push_back(widx(bus.st_addr));
                q_data.push_back(bus.st_data);
            end else begin
                m_mis = 1'b1;
            end
        end
    endtask

    initial begin
        forever begin
            @(posedge clk or posedge reset);
            if (reset) begin
                q_idx.delete();
                q_data.delete();
                m_ld_data = 32'h0;
                m_ld_done = 1'b0;
                m_mis     = 1'b0;
            end else begin
                model_step();
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge
    initial begin
        forever begin
            @(negedge clk);
            check("m_count",      32'(bus.count),      32'(q_idx.size()));
            check("m_st_ready",   32'(bus.st_ready),   32'(q_idx.size() != DEPTH));
            check("m_ld_done",    32'(bus.ld_done),    32'(m_ld_done));
            check("m_ld_data",    bus.ld_data,         m_ld_data);
            check("m_misaligned", 32'(bus.misaligned), 32'(m_mis));
        end
    end

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_store(input logic [31:0] a, input logic [31:0] d);
        bus.st_valid = 1'b1;
        bus.st_addr  = a;
        bus.st_data  = d;
        cyc();
        bus.st_valid = 1'b0;
    endtask

    task automatic do_load(input logic [31:0] a);
        bus.ld_valid = 1'b1;
        bus.ld_addr  = a;
        cyc();
        bus.ld_valid = 1'b0;
    endtask

    initial begin
        bus.st_valid = 1'b0;
        bus.st_addr  = 32'h0;
        bus.st_data  = 32'h0;
        bus.ld_valid = 1'b0;
        bus.ld_addr  = 32'h0;
        repeat (2) cyc();
        check("rst_count",    32'(bus.count),      32'd0);
        check("rst_st_ready", 32'(bus.st_ready),   32'd1);
        check("rst_ld_done",  32'(bus.ld_done),    32'd0);
        check("rst_ld_data",  bus.ld_data,         32'h0);
        check("rst_mis",      32'(bus.misaligned), 32'd0);
        reset = 1'b0;

        // Basic store, drain, load from memory
        do_store(32'h10, 32'hDEADBEEF);
        check("t1_count_after_push", 32'(bus.count), 32'd1);
        cyc();
        cyc();
        do_load(32'h10);
        check("t1_ld_done", 32'(bus.ld_done), 32'd1);
        check("t1_ld_data", bus.ld_data, 32'hDEADBEEF);
        check("t1_count",   32'(bus.count), 32'd0);

        // Loads starve the drain until the buffer is full
        bus.ld_valid = 1'b1;
        bus.ld_addr  = 32'h10;
        for (int i = 0; i < 5; i++) begin
            bus.st_valid = 1'b1;
            bus.st_addr  = 32'h100 + 32'(4 * i);
            bus.st_data  = 32'h5000_0000 + 32'(i);
            if (i == 4) check("t2_st_ready_full", 32'(bus.st_ready), 32'd0);
            cyc();
        end
        bus.st_valid = 1'b0;
        check("t2_count_full", 32'(bus.count), 32'd4);
        bus.ld_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            cyc();
            check("t2_drain_count", 32'(bus.count), 32'(3 - k));
        end

        // Youngest matching entry is forwarded, then memory holds it
        bus.ld_valid = 1'b1;
        bus.ld_addr  = 32'h10;
        do_store(32'h20, 32'h11111111);
        do_store(32'h20, 32'h22222222);
        bus.ld_addr = 32'h20;
        cyc();
        check("t3_fwd_youngest", bus.ld_data, 32'h22222222);
        bus.ld_valid = 1'b0;
        repeat (3) cyc();
        do_load(32'h20);
        check("t3_mem_after_drain", bus.ld_data, 32'h22222222);

        // Misaligned store is dropped, flag is sticky
        do_store(32'h3, 32'hBAD0BAD0);
        check("t4_count", 32'(bus.count), 32'd0);
        check("t4_mis",   32'(bus.misaligned), 32'd1);
        do_store(32'h44, 32'h00000005);
        cyc();
        check("t4_mis_sticky", 32'(bus.misaligned), 32'd1);

        // Same-cycle store is ordered after the load
        do_store(32'h40, 32'h12345678);
        cyc();
        cyc();
        bus.st_valid = 1'b1;
        bus.st_addr  = 32'h40;
        bus.st_data  = 32'hAAAA0000;
        bus.ld_valid = 1'b1;
        bus.ld_addr  = 32'h40;
        cyc();
        bus.st_valid = 1'b0;
        check("t5_load_before_store", bus.ld_data, 32'h12345678);
        cyc();
        check("t5_load_after_store", bus.ld_data, 32'hAAAA0000);
        bus.ld_valid = 1'b0;
        repeat (2) cyc();

        // Reset with pending entries and a load in flight
        bus.ld_valid = 1'b1;
        bus.ld_addr  = 32'h10;
        do_store(32'h10, 32'h00000001);
        do_store(32'h20, 32'h00000002);
        do_store(32'h40, 32'h00000003);
        check("t6_count_filled", 32'(bus.count), 32'd3);
        #2 reset = 1'b1;
        #1;
        check("t6_rst_count",    32'(bus.count),      32'd0);
        check("t6_rst_ld_done",  32'(bus.ld_done),    32'd0);
        check("t6_rst_ld_data",  bus.ld_data,         32'h0);
        check("t6_rst_mis",      32'(bus.misaligned), 32'd0);
        check("t6_rst_st_ready", 32'(bus.st_ready),   32'd1);
        @(posedge clk);
        #1;
        check("t6_rst_no_done", 32'(bus.ld_done), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        bus.ld_valid = 1'b0;
        do_load(32'h10);
        check("t6_mem_10", bus.ld_data, 32'hDEADBEEF);
        do_load(32'h20);
        check("t6_mem_20", bus.ld_data, 32'h22222222);
        do_load(32'h40);
        check("t6_mem_40", bus.ld_data, 32'hAAAA0000);

        // Address wrap and misaligned load
        do_load(32'h410);
        check("t7_wrap", bus.ld_data, 32'hDEADBEEF);
        do_load(32'h5);
        check("t7_mis_ld_done", 32'(bus.ld_done),    32'd1);
        check("t7_mis_ld_data", bus.ld_data,         32'h0);
        check("t7_mis_flag",    32'(bus.misaligned), 32'd1);
        cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
